// File: rtl/seq_shift_add_mult.sv
// Iterative unsigned shift-and-add multiplier with valid/ready on both sides.
// Optional saturation of the narrowed product is enabled by defining MULT_SAT_EN.
module seq_shift_add_mult #(
  parameter int unsigned A_WIDTH = 9,
  parameter int unsigned B_WIDTH = 4,
  parameter int unsigned P_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_WIDTH-1:0] a,
  input  logic [B_WIDTH-1:0] b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [P_WIDTH-1:0] product,
  output logic               ovf
);

  localparam int unsigned FullW = A_WIDTH + B_WIDTH;
  localparam int unsigned CntW  = $clog2(B_WIDTH + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(B_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e             state_q, state_d;
  logic [FullW-1:0]   a_sh_q, a_sh_d;
  logic [B_WIDTH-1:0] b_sh_q, b_sh_d;
  logic [FullW-1:0]   acc_q, acc_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [P_WIDTH-1:0] product_q, product_d;
  logic               ovf_q, ovf_d;

  logic [FullW-1:0]   acc_step;
  logic [P_WIDTH-1:0] prod_res;
  logic               ovf_res;

  // Accumulator value after the current step, including this step's add.
  assign acc_step = acc_q + (b_sh_q[0] ? a_sh_q : '0);

  if (P_WIDTH >= FullW) begin : g_wide
    assign prod_res = P_WIDTH'(acc_step);
    assign ovf_res  = 1'b0;
  end else begin : g_narrow
`ifdef MULT_SAT_EN
    logic hi_set;
    assign hi_set   = |acc_step[FullW-1:P_WIDTH];
    assign prod_res = hi_set ? '1 : acc_step[P_WIDTH-1:0];
    assign ovf_res  = hi_set;
`else
    assign prod_res = acc_step[P_WIDTH-1:0];
    assign ovf_res  = 1'b0;
`endif
  end

  assign in_ready  = (state_q == StIdle) && !rst;
  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign ovf       = ovf_q;

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    product_d   = product_q;
    ovf_d       = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_sh_d  = FullW'(a);
          b_sh_d  = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        acc_d  = acc_step;
        a_sh_d = a_sh_q << 1;
        b_sh_d = b_sh_q >> 1;
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          product_d   = prod_res;
          ovf_d       = ovf_res;
          out_valid_d = 1'b1;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      product_q   <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      product_q   <= product_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Bench for seq_shift_add_mult: default build, an 8-bit product build and a
// single-step build, checked against plain-arithmetic expectations.
module tb_seq_shift_add_mult;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Default configuration.
  logic        in_valid = 1'b0, out_ready = 1'b1;
  logic [8:0]  a_i = '0;
  logic [3:0]  b_i = '0;
  logic        in_ready, out_valid, ovf;
  logic [15:0] product;

  seq_shift_add_mult u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a_i), .b(b_i),
    .out_valid(out_valid), .out_ready(out_ready), .product(product), .ovf(ovf)
  );

  // Narrow product.
  logic       v8 = 1'b0;
  logic [8:0] a8 = '0;
  logic [3:0] b8 = '0;
  logic       rdy8, ov8, ovf8;
  logic [7:0] p8;

  seq_shift_add_mult #(.A_WIDTH(9), .B_WIDTH(4), .P_WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(1'b1), .product(p8), .ovf(ovf8)
  );

  // Single-step multiplier.
  logic        v1 = 1'b0;
  logic [11:0] a1 = '0;
  logic [0:0]  b1 = '0;
  logic        rdy1, ov1, ovf1;
  logic [12:0] p1;

  seq_shift_add_mult #(.A_WIDTH(12), .B_WIDTH(1), .P_WIDTH(13)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .a(a1), .b(b1),
    .out_valid(ov1), .out_ready(1'b1), .product(p1), .ovf(ovf1)
  );

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0 || rdy8 !== 1'b0 || rdy1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_in_ready got=%b%b%b want=000", in_ready, rdy8, rdy1);
    end
    total++;
    if (out_valid !== 1'b0 || product !== 16'd0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs got ov=%b p=%0d ovf=%b want 0/0/0", out_valid, product, ovf);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release in_ready got=%b want=1", in_ready);
    end
  endtask

  // One transaction on the default instance; stall = cycles of out_ready=0 after out_valid.
  task automatic do_op(input logic [8:0] av, input logic [3:0] bv, input int stall,
                       input bit drive_pending, input string name);
    int unsigned full;
    int n;
    full = int'(av) * int'(bv);
    @(negedge clk);
    a_i = av; b_i = bv; in_valid = 1'b1; out_ready = (stall == 0);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL %s accept_timeout in_ready=%b want=1", name, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = drive_pending;
    if (drive_pending) begin
      a_i = 9'd5; b_i = 4'd5;
    end
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (i < 4) begin
        if (out_valid !== 1'b0) begin
          bad++;
          $display("FAIL %s early_valid step=%0d got=%b want=0", name, i, out_valid);
        end
      end else if (out_valid !== 1'b1 || product !== 16'(full) || ovf !== 1'b0) begin
        bad++;
        $display("FAIL %s result got ov=%b p=%0d ovf=%b want ov=1 p=%0d ovf=0",
                 name, out_valid, product, ovf, full);
      end
    end
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b1 || product !== 16'(full) || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL %s hold cyc=%0d got ov=%b p=%0d rdy=%b want ov=1 p=%0d rdy=0",
                 name, s, out_valid, product, in_ready, full);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || product !== 16'(full)) begin
      bad++;
      $display("FAIL %s transfer got ov=%b rdy=%b p=%0d want ov=0 rdy=1 p=%0d",
               name, out_valid, in_ready, product, full);
    end
  endtask

  task automatic test_directed();
    do_op(9'd511, 4'd15, 0, 1'b0, "max");
    do_op(9'd0, 4'd15, 0, 1'b0, "a_zero");
    do_op(9'd300, 4'd0, 0, 1'b0, "b_zero");
    do_op(9'd1, 4'd1, 0, 1'b0, "one");
  endtask

  task automatic test_backpressure();
    do_op(9'd37, 4'd9, 10, 1'b1, "bp_37x9");
    do_op(9'd5, 4'd5, 0, 1'b0, "bp_next");
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    a_i = 9'd200; b_i = 4'd10; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset in_ready_during_rst got=%b want=0", in_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || product !== 16'd0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset state got ov=%b p=%0d rdy=%b want 0/0/1", out_valid, product,
               in_ready);
    end
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset discarded got ov=%b want=0", out_valid);
    end
    do_op(9'd3, 4'd3, 0, 1'b0, "after_rst");
  endtask

  task automatic test_random();
    for (int k = 0; k < 25; k++) begin
      do_op(9'($urandom_range(0, 511)), 4'($urandom_range(0, 15)),
            int'($urandom_range(0, 3)), 1'b0, "rand");
    end
  endtask

  task automatic op8(input logic [8:0] av, input logic [3:0] bv);
    int unsigned full, ep;
    logic eo;
    full = int'(av) * int'(bv);
`ifdef MULT_SAT_EN
    eo = (full > 255);
    ep = eo ? 255 : full;
`else
    eo = 1'b0;
    ep = full % 256;
`endif
    @(negedge clk);
    total++;
    if (rdy8 !== 1'b1) begin
      bad++;
      $display("FAIL narrow_ready got=%b want=1", rdy8);
    end
    a8 = av; b8 = bv; v8 = 1'b1;
    @(posedge clk);
    #1;
    v8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (ov8 !== 1'b1 || p8 !== 8'(ep) || ovf8 !== eo) begin
      bad++;
      $display("FAIL narrow %0dx%0d got ov=%b p=%0d ovf=%b want ov=1 p=%0d ovf=%b",
               av, bv, ov8, p8, ovf8, ep, eo);
    end
    @(posedge clk);
  endtask

  task automatic test_narrow();
    op8(9'd100, 4'd5);
    op8(9'd50, 4'd5);
    for (int k = 0; k < 8; k++) op8(9'($urandom_range(0, 511)), 4'($urandom_range(0, 15)));
  endtask

  task automatic op1(input logic [11:0] av, input logic bv);
    int unsigned full;
    full = bv ? int'(av) : 0;
    @(negedge clk);
    a1 = av; b1 = bv; v1 = 1'b1;
    @(posedge clk);
    #1;
    v1 = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (ov1 !== 1'b1 || p1 !== 13'(full) || ovf1 !== 1'b0) begin
      bad++;
      $display("FAIL single_step %0dx%0d got ov=%b p=%0d want ov=1 p=%0d", av, bv, ov1, p1,
               full);
    end
    @(posedge clk);
  endtask

  task automatic test_single_step();
    op1(12'd4095, 1'b1);
    op1(12'd4095, 1'b0);
    op1(12'($urandom_range(0, 4095)), 1'b1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    test_reset();
    test_directed();
    test_backpressure();
    test_mid_reset();
    test_random();
    test_narrow();
    test_single_step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
